// File: rtl/ice_echo_int_pkg.sv
// Shared types and constants for the ICE echo responder: FSM encoding,
// tail status codes and default bus addresses.
package ice_echo_int_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAPTURE   = 3'd1,
        ST_REQUEST   = 3'd2,
        ST_SEND_HDR  = 3'd3,
        ST_SEND_DATA = 3'd4,
        ST_SEND_TAIL = 3'd5
    } echo_state_e;

    localparam logic [7:0] ECHO_OK          = 8'h00;
    localparam logic [7:0] ECHO_TRUNC       = 8'h01;
    localparam logic [7:0] ECHO_CKSUM_TRUNC = 8'hFF;

    localparam logic [7:0] ECHO_ADDR_DEF = 8'h65;
    localparam logic [7:0] RESP_ADDR_DEF = 8'h45;

    // States in which the block owns the slave output bus.
    function automatic logic is_send(input echo_state_e s);
        return (s == ST_SEND_HDR) || (s == ST_SEND_DATA) || (s == ST_SEND_TAIL);
    endfunction

endpackage

// File: rtl/ice_echo_int_if.sv
// ICE master/slave bus as seen by one slave: master frame inputs plus the
// OR-combined slave response outputs and the arbiter handshake.
interface ice_echo_int_if;

    logic [7:0] ma_data;
    logic [7:0] ma_addr;
    logic       ma_data_valid;
    logic       ma_frame_valid;

    logic       sl_overflow;
    logic       sl_arb_request;
    logic       sl_arb_grant;
    logic [8:0] sl_addr;
    logic [8:0] sl_data;
    logic [8:0] sl_tail;
    logic       sl_latch_tail;

    modport master (
        output ma_data, ma_addr, ma_data_valid, ma_frame_valid, sl_arb_grant,
        input  sl_overflow, sl_arb_request, sl_addr, sl_data, sl_tail, sl_latch_tail
    );

    modport slave (
        input  ma_data, ma_addr, ma_data_valid, ma_frame_valid, sl_arb_grant,
        output sl_overflow, sl_arb_request, sl_addr, sl_data, sl_tail, sl_latch_tail
    );

endinterface

// File: rtl/ice_echo_fifo.sv
// Single-clock byte FIFO with show-ahead read data, full/empty flags,
// a one-entry-left flag and a synchronous flush.
module ice_echo_fifo #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush_i,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_en_i,
    output logic [7:0] rd_data_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       last_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_inc;
    logic [7:0]          mem_q [DEPTH];
    logic                wr_fire, rd_fire;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o     = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                        (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign rd_ptr_inc = rd_ptr_q + 1'b1;
    assign last_o     = (rd_ptr_inc == wr_ptr_q);
    assign rd_data_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    assign wr_fire = wr_en_i && !full_o;
    assign rd_fire = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_d = rd_ptr_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/ice_echo_int.sv
// ICE echo responder: captures a frame addressed to ECHO_ADDR and replays it
// as header/data/tail on the slave bus. ICE_ECHO_CHECKSUM_EN puts a byte sum in the tail.
module ice_echo_int
    import ice_echo_int_pkg::*;
#(
    parameter logic [7:0] ECHO_ADDR  = ECHO_ADDR_DEF,
    parameter logic [7:0] RESP_ADDR  = RESP_ADDR_DEF,
    parameter int         DEPTH_LOG2 = 6
) (
    input  logic          clk,
    input  logic          reset,
    ice_echo_int_if.slave bus
);

    echo_state_e state_q, state_d;
    logic        trunc_q, trunc_d;
    logic [7:0]  status;

    logic        echo_hit, capturing, wr_req, wr_en, rd_en;
    logic        ovf_cap, ovf_busy, grant_lost, done;
    logic        fifo_full, fifo_empty, fifo_last;
    logic [7:0]  fifo_rd_data;

    assign echo_hit   = bus.ma_frame_valid && (bus.ma_addr == ECHO_ADDR);
    // The first byte may ride along with the frame start while still in IDLE.
    assign capturing  = (state_q == ST_CAPTURE) || ((state_q == ST_IDLE) && echo_hit);
    assign wr_req     = capturing && bus.ma_data_valid;
    assign wr_en      = wr_req && !fifo_full;
    assign ovf_cap    = wr_req && fifo_full;
    assign ovf_busy   = ((state_q == ST_REQUEST) || is_send(state_q)) &&
                        echo_hit && bus.ma_data_valid;
    assign grant_lost = is_send(state_q) && !bus.sl_arb_grant;
    assign rd_en      = (state_q == ST_SEND_DATA) && bus.sl_arb_grant;
    assign done       = (state_q == ST_SEND_TAIL) || grant_lost;

    ice_echo_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (grant_lost),
        .wr_en_i   (wr_en),
        .wr_data_i (bus.ma_data),
        .rd_en_i   (rd_en),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .last_o    (fifo_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        trunc_d = trunc_q;
        unique case (state_q)
            ST_IDLE:      if (echo_hit) state_d = ST_CAPTURE;
            ST_CAPTURE:   if (!bus.ma_frame_valid) state_d = ST_REQUEST;
            ST_REQUEST:   if (bus.sl_arb_grant) state_d = ST_SEND_HDR;
            ST_SEND_HDR:  state_d = fifo_empty ? ST_SEND_TAIL : ST_SEND_DATA;
            ST_SEND_DATA: if (fifo_last) state_d = ST_SEND_TAIL;
            ST_SEND_TAIL: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        if (grant_lost) state_d = ST_IDLE;
        if (ovf_cap)    trunc_d = 1'b1;
        if (done)       trunc_d = 1'b0;
    end

`ifdef ICE_ECHO_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (wr_en) sum_d = sum_q + bus.ma_data;
        if (done)  sum_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    assign status = trunc_q ? ECHO_CKSUM_TRUNC : sum_q;
`else
    assign status = trunc_q ? ECHO_TRUNC : ECHO_OK;
`endif

    // Strobes are gated by grant so nothing reaches the OR-combined bus
    // in the cycle the arbiter takes it away.
    always_comb begin
        bus.sl_overflow    = ovf_cap || ovf_busy;
        bus.sl_arb_request = (state_q == ST_REQUEST) || is_send(state_q);
        bus.sl_addr        = '0;
        bus.sl_data        = '0;
        bus.sl_tail        = '0;
        bus.sl_latch_tail  = 1'b0;
        if (bus.sl_arb_grant) begin
            unique case (state_q)
                ST_SEND_HDR:  bus.sl_addr = {1'b1, RESP_ADDR};
                ST_SEND_DATA: bus.sl_data = {1'b1, fifo_rd_data};
                ST_SEND_TAIL: begin
                    bus.sl_tail       = {1'b1, status};
                    bus.sl_latch_tail = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
